// File: rtl/group4_project_system_nios2_qsys_0_div_cell_pkg.sv
// Shared types and constants for the A-stage iterative divider.
package nios2_div_pkg;

    // Control sequence: operand capture, magnitude prep, one bit per cycle, sign fix-up.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_t;

    // Default datapath width and the matching iteration counter width.
    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // Quotient reported for a zero divisor, in either signed or unsigned mode.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/group4_project_system_nios2_qsys_0_div_cell_if.sv
// CPU-side request/response bundle for the divide cell.
// The CPU (master) issues operands and a start pulse; the divider (slave)
// answers with busy, a done pulse and held results.
interface group4_project_system_nios2_qsys_0_div_cell_if #(
    parameter int WIDTH = 32
);
    logic             A_div_start;
    logic             A_div_signed;
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quotient;
    logic [WIDTH-1:0] A_div_remainder;

    modport master (
        output A_div_start,
        output A_div_signed,
        output A_div_src1,
        output A_div_src2,
        input  A_div_busy,
        input  A_div_done,
        input  A_div_quotient,
        input  A_div_remainder
    );

    modport slave (
        input  A_div_start,
        input  A_div_signed,
        input  A_div_src1,
        input  A_div_src2,
        output A_div_busy,
        output A_div_done,
        output A_div_quotient,
        output A_div_remainder
    );

endinterface

// File: rtl/group4_project_system_nios2_qsys_0_div_cell_div_step.sv
// One combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits. The partial remainder is always below the divisor, so
// a set MSB of the old remainder means the shifted value already exceeds any
// WIDTH-bit divisor; that carry is folded into the compare so the subtraction
// itself only needs WIDTH bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted;
    logic             shiftCarry;
    logic [WIDTH-1:0] trial;

    // Trial subtraction and restore/keep decision for this bit position.
    always_comb begin
        shifted    = {rem[WIDTH-2:0], dvd_msb};
        shiftCarry = rem[WIDTH-1];
        trial      = shifted - divisor;
        q_bit      = shiftCarry | (shifted >= divisor);
        next_rem   = q_bit ? trial : shifted;
    end

endmodule

// File: rtl/group4_project_system_nios2_qsys_0_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II A-stage.
// Works on unsigned magnitudes and applies C-style truncating sign rules at
// the end. Results land in the output registers on the final iteration edge,
// so they are valid in the single cycle that done is high.
module group4_project_system_nios2_qsys_0_div_cell
    import nios2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic clk,
    input  logic reset,
    group4_project_system_nios2_qsys_0_div_cell_if.slave divIf
);

    localparam int CntW = (WIDTH == DIV_WIDTH) ? CNT_W : $clog2(WIDTH);

    div_state_t       state_q,     state_d;
    logic [CntW-1:0]  counter_q,   counter_d;
    logic             signedOp_q,  signedOp_d;
    logic [WIDTH-1:0] src1_q,      src1_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic [WIDTH-1:0] dvd_q,       dvd_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic             qNeg_q,      qNeg_d;
    logic             rNeg_q,      rNeg_d;
    logic             div0_q,      div0_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic [WIDTH-1:0] stepRem;
    logic             stepQBit;
    logic [WIDTH-1:0] rawQuotient;
    logic [WIDTH-1:0] div0Quotient;

    // dvd_q doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    div_step #(
        .WIDTH(WIDTH)
    ) uStep (
        .rem     (rem_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .divisor (divisor_q),
        .next_rem(stepRem),
        .q_bit   (stepQBit)
    );

    assign rawQuotient  = {dvd_q[WIDTH-2:0], stepQBit};
    assign div0Quotient = {WIDTH{DIV0_QUOTIENT[0]}};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start outside IDLE is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (divIf.A_div_start) state_d = PREP;
            PREP:    state_d = ITER;
            ITER:    if (counter_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so they come straight from flops.
    always_comb begin
        busy_d = (state_d == PREP) || (state_d == ITER);
        done_d = (state_d == FIX);
    end

    // Datapath next values: capture, magnitude prep, shift/subtract, fix-up.
    always_comb begin
        counter_d   = counter_q;
        signedOp_d  = signedOp_q;
        src1_d      = src1_q;
        divisor_d   = divisor_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        qNeg_d      = qNeg_q;
        rNeg_d      = rNeg_q;
        div0_d      = div0_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: begin
                if (divIf.A_div_start) begin
                    src1_d     = divIf.A_div_src1;
                    divisor_d  = divIf.A_div_src2;
                    signedOp_d = divIf.A_div_signed;
                end
            end
            PREP: begin
                dvd_d     = (signedOp_q && src1_q[WIDTH-1])    ? -src1_q    : src1_q;
                divisor_d = (signedOp_q && divisor_q[WIDTH-1]) ? -divisor_q : divisor_q;
                qNeg_d    = signedOp_q && (src1_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
                rNeg_d    = signedOp_q && src1_q[WIDTH-1];
                div0_d    = (divisor_q == '0);
                counter_d = CntW'(WIDTH - 1);
                rem_d     = '0;
            end
            ITER: begin
                rem_d     = stepRem;
                dvd_d     = rawQuotient;
                counter_d = counter_q - CntW'(1);
                if (counter_q == '0) begin
                    if (div0_q) begin
                        quotient_d  = div0Quotient;
                        remainder_d = src1_q;
                    end else begin
                        quotient_d  = qNeg_q ? -rawQuotient : rawQuotient;
                        remainder_d = rNeg_q ? -stepRem     : stepRem;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q   <= '0;
            signedOp_q  <= 1'b0;
            src1_q      <= '0;
            divisor_q   <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            qNeg_q      <= 1'b0;
            rNeg_q      <= 1'b0;
            div0_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            signedOp_q  <= signedOp_d;
            src1_q      <= src1_d;
            divisor_q   <= divisor_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            qNeg_q      <= qNeg_d;
            rNeg_q      <= rNeg_d;
            div0_q      <= div0_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign divIf.A_div_busy      = busy_q;
    assign divIf.A_div_done      = done_q;
    assign divIf.A_div_quotient  = quotient_q;
    assign divIf.A_div_remainder = remainder_q;

endmodule

// File: tb/tb_group4_project_system_nios2_qsys_0_div_cell.sv
// Self-checking bench for the A-stage divide cell: fixed vectors, multi-cycle
// corner sequences and randomized operations against a plain-arithmetic model.
module tb_group4_project_system_nios2_qsys_0_div_cell;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    group4_project_system_nios2_qsys_0_div_cell_if #(.WIDTH(W)) divIf();

    group4_project_system_nios2_qsys_0_div_cell #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .divIf(divIf)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expQ;
        logic [31:0] expR;
    } vec_t;

    localparam int NumVecs = 10;
    vec_t vecs [NumVecs];

    // One comparison; reports only when the values differ.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Truncating division as C defines it, plus the zero-divisor convention.
    function automatic void refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
        longint na;
        longint nb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            na = sgn ? longint'($signed(a)) : longint'(a);
            nb = sgn ? longint'($signed(b)) : longint'(b);
            lq = na / nb;
            lr = na % nb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Issue one start pulse and follow it until done or a cycle budget runs out.
    // lat is the number of cycles from the start cycle to the done cycle.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output int lat, output int busyCnt);
        @(negedge clk);
        divIf.A_div_start  = 1'b1;
        divIf.A_div_signed = sgn;
        divIf.A_div_src1   = a;
        divIf.A_div_src2   = b;
        lat     = -1;
        busyCnt = 0;
        q       = '0;
        r       = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            divIf.A_div_start = 1'b0;
            if (divIf.A_div_busy) busyCnt++;
            if (divIf.A_div_done) begin
                lat = k;
                q   = divIf.A_div_quotient;
                r   = divIf.A_div_remainder;
                break;
            end
        end
    endtask

    // Safety net so a stuck design still ends the run.
    initial begin
        #(1_500_000);
        $display("[TB] FAIL watchdog: got still running, want finished");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] q1;
        logic [31:0] r1;
        logic [31:0] q2;
        logic [31:0] r2;
        logic [31:0] expQ;
        logic [31:0] expR;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        sawDone;
        logic        doneAt35;
        int          lat;
        int          busyCnt;
        int          doneK1;
        int          doneK2;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2};
        vecs[3] = '{1'b0, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF, 32'h0000_1234};
        vecs[4] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0};
        vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        vecs[8] = '{1'b0, 32'd7,          32'd100,      32'd0,        32'd7};
        vecs[9] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};

        reset              = 1'b1;
        divIf.A_div_start  = 1'b0;
        divIf.A_div_signed = 1'b0;
        divIf.A_div_src1   = '0;
        divIf.A_div_src2   = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy",      {31'd0, divIf.A_div_busy}, 32'd0);
        checkOutput("reset done",      {31'd0, divIf.A_div_done}, 32'd0);
        checkOutput("reset quotient",  divIf.A_div_quotient,      32'd0);
        checkOutput("reset remainder", divIf.A_div_remainder,     32'd0);
        reset = 1'b0;

        for (int i = 0; i < NumVecs; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, lat, busyCnt);
            checkOutput($sformatf("vec%0d quotient", i),  q,            vecs[i].expQ);
            checkOutput($sformatf("vec%0d remainder", i), r,            vecs[i].expR);
            checkOutput($sformatf("vec%0d latency", i),   32'(lat),     32'd34);
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCnt), 32'd33);
        end

        repeat (5) @(negedge clk);
        checkOutput("hold quotient",  divIf.A_div_quotient,      vecs[NumVecs-1].expQ);
        checkOutput("hold remainder", divIf.A_div_remainder,     vecs[NumVecs-1].expR);
        checkOutput("hold done low",  {31'd0, divIf.A_div_done}, 32'd0);

        // Starts during an operation are ignored; a start right after done is taken.
        @(negedge clk);
        divIf.A_div_start  = 1'b1;
        divIf.A_div_signed = 1'b0;
        divIf.A_div_src1   = 32'd50;
        divIf.A_div_src2   = 32'd5;
        doneK1   = -1;
        doneK2   = -1;
        doneAt35 = 1'b0;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            divIf.A_div_start = 1'b0;
            if (k == 5 || k == 20) begin
                divIf.A_div_start  = 1'b1;
                divIf.A_div_signed = 1'b1;
                divIf.A_div_src1   = 32'd1000;
                divIf.A_div_src2   = 32'd3;
            end
            if (k == 35) begin
                divIf.A_div_start  = 1'b1;
                divIf.A_div_signed = 1'b0;
                divIf.A_div_src1   = 32'd77;
                divIf.A_div_src2   = 32'd4;
                doneAt35           = divIf.A_div_done;
            end
            if (divIf.A_div_done) begin
                if (doneK1 < 0) begin
                    doneK1 = k;
                    q1 = divIf.A_div_quotient;
                    r1 = divIf.A_div_remainder;
                end else if (doneK2 < 0) begin
                    doneK2 = k;
                    q2 = divIf.A_div_quotient;
                    r2 = divIf.A_div_remainder;
                end
            end
            if (doneK2 >= 0) break;
        end
        checkOutput("ignore-start done cycle",  32'(doneK1),        32'd34);
        checkOutput("ignore-start quotient",    q1,                 32'd10);
        checkOutput("ignore-start remainder",   r1,                 32'd0);
        checkOutput("done single-cycle",        {31'd0, doneAt35},  32'd0);
        checkOutput("back-to-back done cycle",  32'(doneK2),        32'd69);
        checkOutput("back-to-back quotient",    q2,                 32'd19);
        checkOutput("back-to-back remainder",   r2,                 32'd1);

        // Reset in the middle of an operation aborts it without a done pulse.
        @(negedge clk);
        divIf.A_div_start  = 1'b1;
        divIf.A_div_signed = 1'b0;
        divIf.A_div_src1   = 32'h0000_FFFF;
        divIf.A_div_src2   = 32'd3;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            divIf.A_div_start = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busy",      {31'd0, divIf.A_div_busy}, 32'd0);
        checkOutput("abort done",      {31'd0, divIf.A_div_done}, 32'd0);
        checkOutput("abort quotient",  divIf.A_div_quotient,      32'd0);
        checkOutput("abort remainder", divIf.A_div_remainder,     32'd0);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (divIf.A_div_done) sawDone = 1'b1;
        end
        checkOutput("abort no done pulse", {31'd0, sawDone}, 32'd0);

        applyStimulus(1'b0, 32'd9, 32'd2, q, r, lat, busyCnt);
        checkOutput("after-abort quotient",  q,        32'd4);
        checkOutput("after-abort remainder", r,        32'd1);
        checkOutput("after-abort latency",   32'(lat), 32'd34);

        // Randomized operations in both modes, biased toward small, zero and extreme operands.
        for (int n = 0; n < 2000; n++) begin
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            else                           ra = $urandom >> $urandom_range(0, 8);
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            refDiv(rs, ra, rb, expQ, expR);
            applyStimulus(rs, ra, rb, q, r, lat, busyCnt);
            checkOutput($sformatf("rand%0d quotient s=%0d a=0x%08h b=0x%08h", n, rs, ra, rb), q, expQ);
            checkOutput($sformatf("rand%0d remainder s=%0d a=0x%08h b=0x%08h", n, rs, ra, rb), r, expR);
            checkOutput($sformatf("rand%0d latency", n), 32'(lat), 32'd34);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
